ioctl_feeder: RTL and testbench



---
 rtl/ioctl_feeder.sv | 175 +++++++++++++++++
 tb/tb_ioctl_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_feeder.sv
// Download sequencer: paces a host byte stream onto the ioctl_* bus with
// fixed setup, inter-write gap and tail windows so ROM loading is repeatable.
module ioctl_feeder #(
    parameter int SETUP_CYC = 16,
    parameter int WR_GAP    = 4,
    parameter int TAIL_CYC  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  index_in,
    input  logic [24:0] len,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        ioctl_download,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_index,
    input  logic        ioctl_wait,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_GAP   = 3'd4,
        S_TAIL  = 3'd5
    } state_t;

    localparam logic [15:0] SETUP_END = 16'(SETUP_CYC - 1);
    localparam logic [15:0] GAP_END   = 16'(WR_GAP - 1);
    localparam logic [15:0] TAIL_END  = 16'(TAIL_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [24:0] r_len;
    logic [24:0] r_count;
    logic        r_byte_ready;
    logic        r_download;
    logic        r_wr;
    logic [24:0] r_addr;
    logic [7:0]  r_dout;
    logic [7:0]  r_index;
    logic        r_busy;
    logic        r_done;
    logic        w_accept;
    logic        w_last;
    logic        w_cnt_run;

    // Host handshake: a byte transfers on a rising edge where byte_valid and
    // byte_ready are both high; byte_ready is registered and only asserted in
    // FETCH, so at most one byte is taken per write slot. abort wins over it.
    assign w_accept  = (r_state == S_FETCH) && byte_valid && r_byte_ready && !abort;
    assign w_last    = (r_count + 25'd1) == r_len;
    assign w_cnt_run = (r_state == S_SETUP) || (r_state == S_TAIL) ||
                       ((r_state == S_GAP) && !ioctl_wait);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (len != 25'd0)) w_next = S_SETUP;
            end
            S_SETUP: begin
                if (abort)                   w_next = S_TAIL;
                else if (r_cnt == SETUP_END) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (abort)         w_next = S_TAIL;
                else if (w_accept) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (abort || w_last) w_next = S_TAIL;
                else if (WR_GAP == 0) w_next = S_FETCH;
                else                  w_next = S_GAP;
            end
            S_GAP: begin
                if (abort)                                w_next = S_TAIL;
                else if (!ioctl_wait && r_cnt == GAP_END) w_next = S_FETCH;
            end
            S_TAIL: begin
                if (r_cnt == TAIL_END) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shared window counter restarts on every state change and freezes in GAP
    // while the consumer stalls.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 16'd0;
        end else if (w_cnt_run) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_len        <= 25'd0;
            r_count      <= 25'd0;
            r_byte_ready <= 1'b0;
            r_download   <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= 25'd0;
            r_dout       <= 8'd0;
            r_index      <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wr         <= (w_next == S_WRITE);
            r_byte_ready <= (w_next == S_FETCH) && !ioctl_wait;
            r_busy       <= (w_next != S_IDLE);
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != 25'd0) begin
                            r_len      <= len;
                            r_index    <= index_in;
                            r_addr     <= 25'd0;
                            r_count    <= 25'd0;
                            r_download <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_accept) r_dout <= byte_data;
                end
                S_WRITE: begin
                    r_count <= r_count + 25'd1;
                    r_addr  <= r_addr + 25'd1;
                end
                S_TAIL: begin
                    if (w_next == S_IDLE) begin
                        r_download <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready     = r_byte_ready;
    assign ioctl_download = r_download;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign busy           = r_busy;
    assign done           = r_done;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ioctl_feeder.sv
// Bench for ioctl_feeder: table of whole transfers with timing expectations,
// then hand sequences for stalls, valid gaps, abort, len 0, busy start, reset.
module tb_ioctl_feeder;

    localparam int SETUP_CYC = 16;
    localparam int WR_GAP    = 4;
    localparam int TAIL_CYC  = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  index_in = 8'd0;
    logic [24:0] len = 25'd0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    ioctl_feeder #(.SETUP_CYC(SETUP_CYC), .WR_GAP(WR_GAP), .TAIL_CYC(TAIL_CYC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .index_in(index_in),
        .len(len), .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected {addr, data} per write, and host bytes to offer.
    typedef logic [32:0] wr_t;
    wr_t        exp_q[$];
    logic [7:0] host_q[$];
    int         wr_cyc_q[$];
    bit         host_hold = 1'b0;

    int cyc = 0;
    int wr_n = 0, done_n = 0, rise_n = 0;
    int rise_cyc = 0, fall_cyc = 0, ready_cyc = 0, done_cyc = 0;
    int last_acc_cyc = -10, last_wr_cyc = 0, start_cyc = 0;
    bit ready_seen = 1'b1;
    bit acc_pending = 1'b0;
    logic prev_dl = 1'b0;

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        acc_pending = byte_valid && byte_ready;
        if (acc_pending) last_acc_cyc = cyc;
        if (ioctl_wr) begin
            wr_n++;
            wr_cyc_q.push_back(cyc);
            last_wr_cyc = cyc;
            check("wr_after_accept", cyc, last_acc_cyc + 1);
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("wr_addr_data", {ioctl_addr, ioctl_dout}, exp_q.pop_front());
        end
        if (ioctl_download && !prev_dl) begin
            rise_n++;
            rise_cyc = cyc;
            ready_seen = 1'b0;
        end
        if (!ioctl_download && prev_dl) fall_cyc = cyc;
        if (byte_ready && !ready_seen) begin
            ready_seen = 1'b1;
            ready_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        prev_dl = ioctl_download;
    end

    // Host byte driver: pops a byte after the edge that transferred it.
    always @(posedge clk_sys) begin
        #1;
        if (acc_pending && host_q.size() > 0) void'(host_q.pop_front());
        acc_pending = 1'b0;
        byte_valid = !host_hold && (host_q.size() > 0);
        byte_data  = (host_q.size() > 0) ? host_q[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            host_q.push_back(base + 8'(i));
            exp_q.push_back({25'(i), base + 8'(i)});
        end
    endtask

    task automatic do_start(input logic [24:0] l, input logic [7:0] idx);
        @(posedge clk_sys);
        #2;
        len = l;
        index_in = idx;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk_sys);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_n;
        int i = 0;
        while (done_n == d0 && i < budget) begin
            @(posedge clk_sys);
            i++;
        end
        check({name, "_done_seen"}, done_n - d0, 1);
        #2;
    endtask

    task automatic wait_wr(input string name, input int budget);
        int i = 0;
        do begin
            @(negedge clk_sys);
            i++;
        end while (!ioctl_wr && i < budget);
        check({name, "_wr_seen"}, ioctl_wr, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_download"}, ioctl_download, 0);
        check({name, "_wr"}, ioctl_wr, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_ready"}, byte_ready, 0);
        check({name, "_addr"}, ioctl_addr, 0);
        check({name, "_dout"}, ioctl_dout, 0);
        check({name, "_index"}, ioctl_index, 0);
    endtask

    typedef struct {
        logic [24:0] len;
        logic [7:0]  idx;
        logic [7:0]  base;
        int          exp_setup;
        int          exp_spacing;
        int          exp_tail;
        int          exp_wr;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int wr0, d0, r0, abort_cyc, i;

        vecs[0] = '{25'd4, 8'h12, 8'hA0, 16, 6, 17, 4};
        vecs[1] = '{25'd1, 8'hFF, 8'h5C, 16, 6, 17, 1};
        vecs[2] = '{25'd3, 8'h01, 8'hFE, 16, 6, 17, 3};

        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("reset");
        #1;
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            wr0 = wr_n;
            d0 = done_n;
            wr_cyc_q.delete();
            load(int'(vecs[v].len), vecs[v].base);
            do_start(vecs[v].len, vecs[v].idx);
            check("vec_busy", busy, 1);
            wait_done("vec", 400);
            check("vec_rise_latency", rise_cyc - start_cyc, 1);
            check("vec_setup", ready_cyc - rise_cyc, vecs[v].exp_setup);
            if (wr_cyc_q.size() > 0) check("vec_first_wr", wr_cyc_q[0] - ready_cyc, 1);
            for (int k = 1; k < wr_cyc_q.size(); k++)
                check("vec_spacing", wr_cyc_q[k] - wr_cyc_q[k-1], vecs[v].exp_spacing);
            check("vec_writes", wr_n - wr0, vecs[v].exp_wr);
            check("vec_tail", fall_cyc - last_wr_cyc, vecs[v].exp_tail);
            check("vec_done_at_fall", done_cyc, fall_cyc);
            check("vec_index", ioctl_index, vecs[v].idx);
            check("vec_busy_idle", busy, 0);
            check("vec_exp_drained", exp_q.size(), 0);
            tick(3);
            check("vec_single_done", done_n - d0, 1);
        end

        // Consumer stall during the GAP after the first write.
        wr0 = wr_n;
        wr_cyc_q.delete();
        load(3, 8'h30);
        do_start(25'd3, 8'h21);
        wait_wr("stall", 200);
        @(posedge clk_sys);
        #2;
        ioctl_wait = 1'b1;
        repeat (10) @(posedge clk_sys);
        #2;
        ioctl_wait = 1'b0;
        wait_done("stall", 400);
        check("stall_writes", wr_n - wr0, 3);
        if (wr_cyc_q.size() == 3) begin
            check("stall_delay", wr_cyc_q[1] - wr_cyc_q[0], WR_GAP + 2 + 10);
            check("stall_after", wr_cyc_q[2] - wr_cyc_q[1], WR_GAP + 2);
        end
        check("stall_exp_drained", exp_q.size(), 0);
        tick(3);

        // byte_valid high while ready is held off, then low, then high again.
        wr0 = wr_n;
        host_hold = 1'b1;
        ioctl_wait = 1'b1;
        load(2, 8'hC0);
        do_start(25'd2, 8'h44);
        i = 0;
        do begin
            @(negedge clk_sys);
            i++;
        end while (dbg_state != 3'd2 && i < 100);
        check("tog_in_fetch", dbg_state, 2);
        @(posedge clk_sys);
        #2;
        host_hold = 1'b0;
        tick(4);
        check("tog_ready_low", byte_ready, 0);
        host_hold = 1'b1;
        ioctl_wait = 1'b0;
        tick(3);
        check("tog_no_wr_yet", wr_n - wr0, 0);
        check("tog_ready_high", byte_ready, 1);
        host_hold = 1'b0;
        wait_done("tog", 300);
        check("tog_writes", wr_n - wr0, 2);
        check("tog_exp_drained", exp_q.size(), 0);
        tick(3);

        // Abort in the GAP after the second write of eight.
        wr0 = wr_n;
        load(8, 8'h80);
        do_start(25'd8, 8'h80);
        wait_wr("abort1", 200);
        wait_wr("abort2", 200);
        @(posedge clk_sys);
        #2;
        abort = 1'b1;
        abort_cyc = cyc;
        @(posedge clk_sys);
        #2;
        abort = 1'b0;
        wait_done("abort", 300);
        check("abort_writes", wr_n - wr0, 2);
        check("abort_tail", fall_cyc - abort_cyc, TAIL_CYC + 1);
        check("abort_unwritten", exp_q.size(), 6);
        exp_q.delete();
        host_q.delete();
        tick(3);

        // len 0: no window, done the next cycle, index untouched.
        d0 = done_n;
        r0 = rise_n;
        do_start(25'd0, 8'h99);
        tick(4);
        check("len0_done", done_n - d0, 1);
        check("len0_done_cycle", done_cyc - start_cyc, 1);
        check("len0_no_window", rise_n - r0, 0);
        check("len0_index", ioctl_index, 8'h80);
        check("len0_busy", busy, 0);

        // start while busy is ignored.
        wr0 = wr_n;
        d0 = done_n;
        r0 = rise_n;
        load(2, 8'h10);
        do_start(25'd2, 8'h33);
        tick(3);
        do_start(25'd5, 8'h77);
        check("busy_start_index", ioctl_index, 8'h33);
        wait_done("busy_start", 300);
        tick(20);
        check("busy_start_writes", wr_n - wr0, 2);
        check("busy_start_windows", rise_n - r0, 1);
        check("busy_start_dones", done_n - d0, 1);
        check("busy_start_final_index", ioctl_index, 8'h33);

        // Reset pulse during a WRITE.
        d0 = done_n;
        load(4, 8'hE0);
        do_start(25'd4, 8'h5A);
        wait_wr("rst", 200);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk_sys);
        reset_n = 1'b1;
        exp_q.delete();
        host_q.delete();
        tick(5);
        check("rst_no_done", done_n - d0, 0);
        check("rst_state_idle", dbg_state, 0);
        wr0 = wr_n;
        load(2, 8'h61);
        do_start(25'd2, 8'h22);
        wait_done("rst_clean", 300);
        check("rst_clean_writes", wr_n - wr0, 2);
        check("rst_clean_exp_drained", exp_q.size(), 0);
        check("rst_clean_index", ioctl_index, 8'h22);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
